var_latency_line: RTL and testbench

VAR_LATENCY_LINE -- requirements
Module: var_latency_line

---
 rtl/var_latency_line.sv | 134 +++++++++++++
 tb/tb_var_latency_line.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/var_latency_line.sv
// var_latency_line: multi-channel delay line with a run-time programmable
// latency L (1..MAX_LATENCY), stall (ce), flush and in-flight sample count.
//
// Ports:
//   clk, rst     rising-edge clock, synchronous active-high reset
//   ce           shift enable; 0 holds every stage
//   flush        discard all in-flight samples
//   lat_wr       strobe loading lat_in as the new latency
//   lat_in       requested latency (0 or > MAX_LATENCY is rejected)
//   din          CHANNELS*DATA_Width input samples, channel 0 in LSBs
//   din_valid    din carries a sample
//   dout         stage L-1 data, forced to zero when dout_valid is low
//   dout_valid   stage L-1 valid bit
//   lat_cur      active latency L
//   lat_err      one-cycle pulse after a rejected lat_wr
//   inflight     valid samples held in stages 0..L-1
module var_latency_line #(
   parameter int unsigned MAX_LATENCY     = 16,
   parameter int unsigned DATA_Width      = 8,
   parameter int unsigned CHANNELS        = 2,
   parameter int unsigned DEFAULT_LATENCY = 7,
   localparam int unsigned LAT_W          = $clog2(MAX_LATENCY + 1),
   localparam int unsigned DW             = CHANNELS * DATA_Width
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ce,
   input  logic             flush,
   input  logic             lat_wr,
   input  logic [LAT_W-1:0] lat_in,
   input  logic [DW-1:0]    din,
   input  logic             din_valid,
   output logic [DW-1:0]    dout,
   output logic             dout_valid,
   output logic [LAT_W-1:0] lat_cur,
   output logic             lat_err,
   output logic [LAT_W-1:0] inflight
);

   // Elaboration-time guard on parameter ranges.
   if (MAX_LATENCY < 1 || MAX_LATENCY > 64) begin : g_bad_max
      $error("var_latency_line: MAX_LATENCY out of range 1..64");
   end
   if (DEFAULT_LATENCY < 1 || DEFAULT_LATENCY > MAX_LATENCY) begin : g_bad_def
      $error("var_latency_line: DEFAULT_LATENCY out of range 1..MAX_LATENCY");
   end

   logic [DW-1:0]          stage_data [MAX_LATENCY];
   logic [MAX_LATENCY-1:0] stage_valid;
   logic [MAX_LATENCY-1:0] valid_shift;
   logic [DW-1:0]          tap_data;
   logic                   tap_valid;
   logic                   lat_legal_c;

   // A latency write is accepted only inside 1..MAX_LATENCY.
   assign lat_legal_c = lat_wr && (lat_in != '0) &&
                        (lat_in <= LAT_W'(MAX_LATENCY));

   // Valid vector after one shift step, din_valid entering stage 0.
   always_comb begin
      valid_shift    = stage_valid << 1;
      valid_shift[0] = din_valid;
   end

   // Tap mux: pick stage L-1; stages at or beyond L never reach the output.
   always_comb begin
      tap_data  = '0;
      tap_valid = 1'b0;
      for (int k = 0; k < int'(MAX_LATENCY); k++) begin
         if (LAT_W'(k + 1) == lat_cur) begin
            tap_data  = stage_data[k];
            tap_valid = stage_valid[k];
         end
      end
   end

   assign dout_valid = tap_valid;
   assign dout       = tap_valid ? tap_data : '0;

   // Data shift register: no reset, masking on dout hides stale contents.
   always_ff @(posedge clk) begin
      if (ce) begin
         for (int k = int'(MAX_LATENCY) - 1; k > 0; k--) begin
            stage_data[k] <= stage_data[k-1];
         end
         stage_data[0] <= din;
      end
   end

   // Valid bits: reset, latency change and flush all empty the line.
   always_ff @(posedge clk) begin
      if (rst) begin
         stage_valid <= '0;
      end else if (lat_legal_c || flush) begin
         stage_valid <= '0;
      end else if (ce) begin
         stage_valid <= valid_shift;
      end
   end

   // Active latency register.
   always_ff @(posedge clk) begin
      if (rst) begin
         lat_cur <= LAT_W'(DEFAULT_LATENCY);
      end else if (lat_legal_c) begin
         lat_cur <= lat_in;
      end
   end

   // Rejected latency write flags for exactly one cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         lat_err <= 1'b0;
      end else begin
         lat_err <= lat_wr && !lat_legal_c;
      end
   end

   // In-flight count: +1 on entry, -1 on exit, guarded against wrap.
   always_ff @(posedge clk) begin
      if (rst) begin
         inflight <= '0;
      end else if (lat_legal_c || flush) begin
         inflight <= '0;
      end else if (ce) begin
         if (din_valid && !tap_valid && (inflight < lat_cur)) begin
            inflight <= inflight + LAT_W'(1);
         end else if (!din_valid && tap_valid && (inflight != '0)) begin
            inflight <= inflight - LAT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_var_latency_line.sv
// tb_var_latency_line: directed vector table plus a ce-toggling ramp for
// var_latency_line at default parameters (L reset value 7, 2x8-bit lanes).
module tb_var_latency_line;

   localparam int unsigned LAT_W = $clog2(16 + 1);
   localparam int unsigned DW    = 16;

   logic             clk = 1'b0;
   logic             rst, ce, flush, lat_wr, din_valid;
   logic [LAT_W-1:0] lat_in;
   logic [DW-1:0]    din;
   logic [DW-1:0]    dout;
   logic             dout_valid, lat_err;
   logic [LAT_W-1:0] lat_cur, inflight;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   var_latency_line dut (
      .clk        (clk),
      .rst        (rst),
      .ce         (ce),
      .flush      (flush),
      .lat_wr     (lat_wr),
      .lat_in     (lat_in),
      .din        (din),
      .din_valid  (din_valid),
      .dout       (dout),
      .dout_valid (dout_valid),
      .lat_cur    (lat_cur),
      .lat_err    (lat_err),
      .inflight   (inflight)
   );

   typedef struct {
      logic             rst, ce, flush, wr;
      logic [LAT_W-1:0] lin;
      logic [DW-1:0]    din;
      logic             dv;
      logic [DW-1:0]    e_dout;
      logic             e_dv;
      logic [LAT_W-1:0] e_lat;
      logic             e_err;
      logic [LAT_W-1:0] e_inf;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic r, input logic c, input logic f,
                               input logic w, input int li, input int d,
                               input logic v, input int ed, input logic edv,
                               input int el, input logic ee, input int ei);
      vec_t t;
      t.rst = r; t.ce = c; t.flush = f; t.wr = w;
      t.lin = LAT_W'(li); t.din = DW'(d); t.dv = v;
      t.e_dout = DW'(ed); t.e_dv = edv; t.e_lat = LAT_W'(el);
      t.e_err = ee; t.e_inf = LAT_W'(ei);
      return t;
   endfunction

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic c, input logic f,
                        input logic w, input logic [LAT_W-1:0] li,
                        input logic [DW-1:0] d, input logic v);
      @(negedge clk);
      rst = r; ce = c; flush = f; lat_wr = w; lat_in = li; din = d;
      din_valid = v;
      @(posedge clk);
      #1;
   endtask

   logic [DW-1:0] acc [64];
   int            e_cnt;
   logic [DW-1:0] exp_dout;
   logic          exp_dv;
   int            exp_inf;

   initial begin
      rst = 1'b1; ce = 1'b0; flush = 1'b0; lat_wr = 1'b0; lat_in = '0;
      din = '0; din_valid = 1'b0;

      // reset, single sample through the default latency of 7
      vecs.push_back(mk(1,0,0,0,0,0,0,       0,0,7,0,0));
      vecs.push_back(mk(0,1,0,0,0,'h0201,1,  0,0,7,0,1));
      for (int i = 0; i < 5; i++)
         vecs.push_back(mk(0,1,0,0,0,0,0,    0,0,7,0,1));
      vecs.push_back(mk(0,1,0,0,0,0,0,       'h0201,1,7,0,1));
      vecs.push_back(mk(0,1,0,0,0,0,0,       0,0,7,0,0));
      // rejected latency writes (0, then 17) while a sample travels
      vecs.push_back(mk(0,1,0,0,0,'h0A0B,1,  0,0,7,0,1));
      vecs.push_back(mk(0,1,0,1,0,0,0,       0,0,7,1,1));
      vecs.push_back(mk(0,1,0,0,0,0,0,       0,0,7,0,1));
      vecs.push_back(mk(0,1,0,1,17,0,0,      0,0,7,1,1));
      vecs.push_back(mk(0,1,0,0,0,0,0,       0,0,7,0,1));
      vecs.push_back(mk(0,1,0,0,0,0,0,       0,0,7,0,1));
      vecs.push_back(mk(0,1,0,0,0,0,0,       'h0A0B,1,7,0,1));
      vecs.push_back(mk(0,1,0,0,0,0,0,       0,0,7,0,0));
      // five in flight, then legal write of latency 3
      for (int i = 1; i <= 5; i++)
         vecs.push_back(mk(0,1,0,0,0,'h10+i,1, 0,0,7,0,i));
      vecs.push_back(mk(0,1,0,1,3,'h16,1,    0,0,3,0,0));
      vecs.push_back(mk(0,1,0,0,0,'h21,1,    0,0,3,0,1));
      vecs.push_back(mk(0,1,0,0,0,0,0,       0,0,3,0,1));
      vecs.push_back(mk(0,1,0,0,0,0,0,       'h21,1,3,0,1));
      vecs.push_back(mk(0,1,0,0,0,0,0,       0,0,3,0,0));
      // fill L=3 completely, stall, drain one
      vecs.push_back(mk(0,1,0,0,0,'h31,1,    0,0,3,0,1));
      vecs.push_back(mk(0,1,0,0,0,'h32,1,    0,0,3,0,2));
      vecs.push_back(mk(0,1,0,0,0,'h33,1,    'h31,1,3,0,3));
      vecs.push_back(mk(0,1,0,0,0,'h34,1,    'h32,1,3,0,3));
      vecs.push_back(mk(0,0,0,0,0,'h99,1,    'h32,1,3,0,3));
      vecs.push_back(mk(0,1,0,0,0,0,0,       'h33,1,3,0,2));
      // legal write with ce=0 still clears the line
      vecs.push_back(mk(0,0,0,1,7,0,0,       0,0,7,0,0));
      // four in flight, flush together with ce=0
      for (int i = 1; i <= 4; i++)
         vecs.push_back(mk(0,1,0,0,0,'h40+i,1, 0,0,7,0,i));
      vecs.push_back(mk(0,0,1,0,0,'h45,1,    0,0,7,0,0));
      vecs.push_back(mk(0,1,0,0,0,'h51,1,    0,0,7,0,1));
      for (int i = 0; i < 5; i++)
         vecs.push_back(mk(0,1,0,0,0,0,0,    0,0,7,0,1));
      vecs.push_back(mk(0,1,0,0,0,0,0,       'h51,1,7,0,1));
      // reset beats lat_wr and flush mid-stream
      vecs.push_back(mk(1,1,1,1,2,'h77,1,    0,0,7,0,0));
      vecs.push_back(mk(0,1,0,1,20,'h61,1,   0,0,7,1,1));
      vecs.push_back(mk(1,0,0,1,0,0,0,       0,0,7,0,0));
      // legal write beats flush; minimum latency 1
      vecs.push_back(mk(0,1,1,1,16,'h62,1,   0,0,16,0,0));
      vecs.push_back(mk(0,1,0,1,1,'h63,1,    0,0,1,0,0));
      vecs.push_back(mk(0,1,0,0,0,'h64,1,    'h64,1,1,0,1));
      vecs.push_back(mk(0,1,0,0,0,'h65,1,    'h65,1,1,0,1));
      vecs.push_back(mk(0,1,0,0,0,0,0,       0,0,1,0,0));
      vecs.push_back(mk(1,0,0,0,0,0,0,       0,0,7,0,0));

      foreach (vecs[i]) begin
         drive(vecs[i].rst, vecs[i].ce, vecs[i].flush, vecs[i].wr,
               vecs[i].lin, vecs[i].din, vecs[i].dv);
         check($sformatf("v%0d dout", i),       32'(dout),       32'(vecs[i].e_dout));
         check($sformatf("v%0d dout_valid", i), 32'(dout_valid), 32'(vecs[i].e_dv));
         check($sformatf("v%0d lat_cur", i),    32'(lat_cur),    32'(vecs[i].e_lat));
         check($sformatf("v%0d lat_err", i),    32'(lat_err),    32'(vecs[i].e_err));
         check($sformatf("v%0d inflight", i),   32'(inflight),   32'(vecs[i].e_inf));
      end

      // ramp with ce toggling: a sample accepted at ce-edge a is visible
      // after ce-edge a+6 (stage L-1 = 6)
      e_cnt = 0;
      for (int c = 0; c < 60; c++) begin
         drive(1'b0, (c % 2) == 0, 1'b0, 1'b0, '0,
               {8'(c + 'h80), 8'(c)}, 1'b1);
         if ((c % 2) == 0) begin
            e_cnt++;
            acc[e_cnt] = {8'(c + 'h80), 8'(c)};
         end
         exp_dv   = (e_cnt >= 7);
         exp_dout = exp_dv ? acc[e_cnt-6] : '0;
         exp_inf  = (e_cnt < 7) ? e_cnt : 7;
         check($sformatf("ramp%0d dout", c),       32'(dout),       32'(exp_dout));
         check($sformatf("ramp%0d dout_valid", c), 32'(dout_valid), 32'(exp_dv));
         check($sformatf("ramp%0d inflight", c),   32'(inflight),   32'(exp_inf));
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
